// File: rtl/logic_trainer_pkg.sv
// Shared definitions for the clocked logic trainer: gate codes, sweep FSM
// states and the number of gates visited by a sweep.
// Optional feature macro: LOGIC_TRAINER_ADD_EN (gate 7 = modular add).
package logic_trainer_pkg;

    localparam logic [2:0] GATE_AND  = 3'd0;
    localparam logic [2:0] GATE_OR   = 3'd1;
    localparam logic [2:0] GATE_NAND = 3'd2;
    localparam logic [2:0] GATE_NOR  = 3'd3;
    localparam logic [2:0] GATE_XOR  = 3'd4;
    localparam logic [2:0] GATE_XNOR = 3'd5;
    localparam logic [2:0] GATE_NOTA = 3'd6;
    localparam logic [2:0] GATE_ADD  = 3'd7;

`ifdef LOGIC_TRAINER_ADD_EN
    localparam int G = 8;
`else
    localparam int G = 7;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STEP  = 2'd1,
        DWELL = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/logic_trainer_alu.sv
// Combinational bitwise gate evaluator for the logic trainer.
// Optional feature macro: LOGIC_TRAINER_ADD_EN (gate 7 = (a+b) mod 2^WIDTH).
module logic_trainer_alu
    import logic_trainer_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [2:0]       sel_i,
    output logic [WIDTH-1:0] y_o
);

    // Select one bitwise operation; unsupported codes yield zero.
    always_comb begin
        y_o = '0;
        case (sel_i)
            GATE_AND:  y_o = a_i & b_i;
            GATE_OR:   y_o = a_i | b_i;
            GATE_NAND: y_o = ~(a_i & b_i);
            GATE_NOR:  y_o = ~(a_i | b_i);
            GATE_XOR:  y_o = a_i ^ b_i;
            GATE_XNOR: y_o = ~(a_i ^ b_i);
            GATE_NOTA: y_o = ~a_i;
`ifdef LOGIC_TRAINER_ADD_EN
            GATE_ADD:  y_o = a_i + b_i;
`endif
            default:   y_o = '0;
        endcase
    end

endmodule

// File: rtl/logic_trainer_seq.sv
// Clocked logic trainer: manual gate evaluation or an unattended sweep over
// every operand pair and gate, each result held for STEP_DIV cycles.
// Optional feature macro: LOGIC_TRAINER_ADD_EN (adds gate 7 to the sweep).
module logic_trainer_seq
    import logic_trainer_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int STEP_DIV = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       sel,
    input  logic             mode,
    input  logic             start,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] cur_a,
    output logic [WIDTH-1:0] cur_b,
    output logic [2:0]       cur_sel,
    output logic             valid,
    output logic             done
);

    localparam int         OW        = 2 * WIDTH;
    localparam int         DW        = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam logic [2:0] LAST_GATE = 3'(G - 1);

    state_t           state_q, state_d;
    logic [OW-1:0]    op_q, op_d;        // {a,b} operand index of the sweep
    logic [2:0]       gate_q, gate_d;    // inner-loop gate of the sweep
    logic [DW-1:0]    dwell_q, dwell_d;  // DWELL cycles already spent
    logic [WIDTH-1:0] y_q, y_d, cur_a_q, cur_a_d, cur_b_q, cur_b_d;
    logic [2:0]       cur_sel_q, cur_sel_d;
    logic             valid_q, valid_d, done_q, done_d;

    logic [WIDTH-1:0] alu_a, alu_b, alu_y;
    logic [2:0]       alu_sel, gate_nx;
    logic [OW-1:0]    op_nx;
    logic             last_step;

    // The single evaluator sees the user inputs in manual mode and the
    // sweep counters in auto mode.
    assign alu_a   = mode ? op_q[OW-1:WIDTH] : a;
    assign alu_b   = mode ? op_q[WIDTH-1:0]  : b;
    assign alu_sel = mode ? gate_q           : sel;

    logic_trainer_alu #(.WIDTH(WIDTH)) u_alu (
        .a_i   (alu_a),
        .b_i   (alu_b),
        .sel_i (alu_sel),
        .y_o   (alu_y)
    );

    // Gate is the inner loop; the operand index only moves after the last gate.
    assign gate_nx   = (gate_q == LAST_GATE) ? 3'd0 : gate_q + 3'd1;
    assign op_nx     = (gate_q == LAST_GATE) ? op_q + OW'(1) : op_q;
    assign last_step = (op_q == {OW{1'b1}}) && (gate_q == LAST_GATE);

    // Next-state and output-register logic for manual mode and the sweep FSM.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        gate_d    = gate_q;
        dwell_d   = dwell_q;
        y_d       = y_q;
        cur_a_d   = cur_a_q;
        cur_b_d   = cur_b_q;
        cur_sel_d = cur_sel_q;
        valid_d   = 1'b0;
        done_d    = 1'b0;
        if (!mode) begin
            state_d   = IDLE;
            op_d      = '0;
            gate_d    = '0;
            dwell_d   = '0;
            y_d       = alu_y;
            cur_a_d   = a;
            cur_b_d   = b;
            cur_sel_d = sel;
            valid_d   = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = STEP;
                        op_d    = '0;
                        gate_d  = '0;
                        dwell_d = '0;
                    end
                end
                STEP: begin
                    y_d       = alu_y;
                    cur_a_d   = alu_a;
                    cur_b_d   = alu_b;
                    cur_sel_d = alu_sel;
                    valid_d   = 1'b1;
                    dwell_d   = '0;
                    if (STEP_DIV > 1) begin
                        state_d = DWELL;
                    end else if (last_step) begin
                        state_d = DONE;
                    end else begin
                        state_d = STEP;
                        gate_d  = gate_nx;
                        op_d    = op_nx;
                    end
                end
                DWELL: begin
                    if (dwell_q == DW'(STEP_DIV - 2)) begin
                        if (last_step) begin
                            state_d = DONE;
                        end else begin
                            state_d = STEP;
                            gate_d  = gate_nx;
                            op_d    = op_nx;
                        end
                    end else begin
                        dwell_d = dwell_q + DW'(1);
                    end
                end
                DONE: begin
                    done_d = !start;
                    if (start) begin
                        state_d = STEP;
                        op_d    = '0;
                        gate_d  = '0;
                        dwell_d = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= '0;
            gate_q    <= '0;
            dwell_q   <= '0;
            y_q       <= '0;
            cur_a_q   <= '0;
            cur_b_q   <= '0;
            cur_sel_q <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            gate_q    <= gate_d;
            dwell_q   <= dwell_d;
            y_q       <= y_d;
            cur_a_q   <= cur_a_d;
            cur_b_q   <= cur_b_d;
            cur_sel_q <= cur_sel_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
        end
    end

    assign y       = y_q;
    assign cur_a   = cur_a_q;
    assign cur_b   = cur_b_q;
    assign cur_sel = cur_sel_q;
    assign valid   = valid_q;
    assign done    = done_q;

endmodule

// File: tb/tb_logic_trainer_seq.sv
// Directed bench: manual vectors on a WIDTH=4 instance, full sweeps on two
// WIDTH=1 instances (STEP_DIV=1 and 4), mid-sweep reset and mode abort.
module tb_logic_trainer_seq;

`ifdef LOGIC_TRAINER_ADD_EN
    localparam int GT = 8;
`else
    localparam int GT = 7;
`endif
    localparam int NS = 4 * GT;   // sweep length for WIDTH=1

    logic clk, rst;
    int   checks, errors;

    // WIDTH=4, STEP_DIV=8
    logic [3:0] u4_a, u4_b, u4_y, u4_ca, u4_cb;
    logic [2:0] u4_sel, u4_cs;
    logic       u4_mode, u4_start, u4_valid, u4_done;
    // WIDTH=1, STEP_DIV=1
    logic       s1_a, s1_b, s1_y, s1_ca, s1_cb, s1_mode, s1_start, s1_valid, s1_done;
    logic [2:0] s1_sel, s1_cs;
    // WIDTH=1, STEP_DIV=4
    logic       s4_a, s4_b, s4_y, s4_ca, s4_cb, s4_mode, s4_start, s4_valid, s4_done;
    logic [2:0] s4_sel, s4_cs;

    logic_trainer_seq #(.WIDTH(4), .STEP_DIV(8)) dut_u4 (
        .clk(clk), .rst(rst), .a(u4_a), .b(u4_b), .sel(u4_sel), .mode(u4_mode),
        .start(u4_start), .y(u4_y), .cur_a(u4_ca), .cur_b(u4_cb), .cur_sel(u4_cs),
        .valid(u4_valid), .done(u4_done));

    logic_trainer_seq #(.WIDTH(1), .STEP_DIV(1)) dut_s1 (
        .clk(clk), .rst(rst), .a(s1_a), .b(s1_b), .sel(s1_sel), .mode(s1_mode),
        .start(s1_start), .y(s1_y), .cur_a(s1_ca), .cur_b(s1_cb), .cur_sel(s1_cs),
        .valid(s1_valid), .done(s1_done));

    logic_trainer_seq #(.WIDTH(1), .STEP_DIV(4)) dut_s4 (
        .clk(clk), .rst(rst), .a(s4_a), .b(s4_b), .sel(s4_sel), .mode(s4_mode),
        .start(s4_start), .y(s4_y), .cur_a(s4_ca), .cur_b(s4_cb), .cur_sel(s4_cs),
        .valid(s4_valid), .done(s4_done));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Truth-table model for a 1-bit gate.
    function automatic logic model1(input logic a, input logic b, input int g);
        case (g)
            0: return a & b;
            1: return a | b;
            2: return ~(a & b);
            3: return ~(a | b);
            4: return a ^ b;
            5: return ~(a ^ b);
            6: return ~a;
`ifdef LOGIC_TRAINER_ADD_EN
            7: return a ^ b;
`endif
            default: return 1'b0;
        endcase
    endfunction

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] sel;
        logic [3:0] y;
    } vec_t;

    vec_t vecs[9];

    initial begin : main
        int   oi, gi;
        logic ea, eb, ey;
        logic la, lb, ly;
        logic [2:0] ls;

        checks = 0;
        errors = 0;
        vecs[0] = '{4'b1100, 4'b1010, 3'd4, 4'b0110};
        vecs[1] = '{4'b1100, 4'b1010, 3'd2, 4'b0111};
        vecs[2] = '{4'b1100, 4'b1010, 3'd6, 4'b0011};
        vecs[3] = '{4'b1100, 4'b1010, 3'd0, 4'b1000};
        vecs[4] = '{4'b1100, 4'b1010, 3'd1, 4'b1110};
        vecs[5] = '{4'b1100, 4'b1010, 3'd3, 4'b0001};
        vecs[6] = '{4'b1100, 4'b1010, 3'd5, 4'b1001};
`ifdef LOGIC_TRAINER_ADD_EN
        vecs[7] = '{4'd3, 4'd5, 3'd7, 4'b1000};
        vecs[8] = '{4'd9, 4'd9, 3'd7, 4'b0010};
`else
        vecs[7] = '{4'd3, 4'd5, 3'd7, 4'b0000};
        vecs[8] = '{4'd9, 4'd9, 3'd7, 4'b0000};
`endif

        rst = 1'b1;
        u4_a = '0; u4_b = '0; u4_sel = '0; u4_mode = 1'b0; u4_start = 1'b0;
        s1_a = '0; s1_b = '0; s1_sel = '0; s1_mode = 1'b0; s1_start = 1'b0;
        s4_a = '0; s4_b = '0; s4_sel = '0; s4_mode = 1'b0; s4_start = 1'b0;
        #2;
        check("reset_u4", 32'({u4_y, u4_ca, u4_cb, u4_cs, u4_valid, u4_done}), 32'd0);
        check("reset_s1", 32'({s1_y, s1_ca, s1_cb, s1_cs, s1_valid, s1_done}), 32'd0);
        tick();
        tick();
        rst = 1'b0;

        // Manual vectors: one edge from inputs to registered result.
        for (int i = 0; i < 9; i++) begin
            u4_a = vecs[i].a; u4_b = vecs[i].b; u4_sel = vecs[i].sel;
            tick();
            $display("manual a=%b b=%b sel=%0d -> y=%b valid=%b", u4_a, u4_b, u4_sel, u4_y, u4_valid);
            check("man_y", 32'(u4_y), 32'(vecs[i].y));
            check("man_cur", 32'({u4_ca, u4_cb, u4_cs}), 32'({vecs[i].a, vecs[i].b, vecs[i].sel}));
            check("man_vd", 32'({u4_valid, u4_done}), 32'b10);
        end

        // Mode 1 without start: IDLE holds y, valid drops.
        u4_mode = 1'b1;
        tick();
        check("idle_hold_y", 32'(u4_y), 32'(vecs[8].y));
        check("idle_valid", 32'(u4_valid), 32'd0);

        // Sweep, WIDTH=1, STEP_DIV=1.
        s1_mode = 1'b1; s1_start = 1'b1;
        tick();
        s1_start = 1'b0;
        check("s1_k_valid", 32'(s1_valid), 32'd0);
        for (int i = 0; i < NS; i++) begin
            tick();
            oi = i / GT; gi = i % GT;
            ea = oi[1]; eb = oi[0]; ey = model1(ea, eb, gi);
            $display("sweep1 step=%0d a=%b b=%b sel=%0d y=%b valid=%b", i, s1_ca, s1_cb, s1_cs, s1_y, s1_valid);
            check("s1_valid", 32'(s1_valid), 32'd1);
            check("s1_done", 32'(s1_done), 32'd0);
            check("s1_cur", 32'({s1_ca, s1_cb, s1_cs}), 32'({ea, eb, 3'(gi)}));
            check("s1_y", 32'(s1_y), 32'(ey));
            if (i == 18) check("s1_step18_y", 32'(s1_y), 32'd1);
        end
        tick();
        check("s1_done_rise", 32'({s1_done, s1_valid}), 32'b10);
        tick();
        check("s1_done_hold", 32'(s1_done), 32'd1);
        check("s1_last_y", 32'(s1_y), 32'(model1(1'b1, 1'b1, GT - 1)));
        s1_start = 1'b1;
        tick();
        s1_start = 1'b0;
        tick();
        check("s1_restart", 32'({s1_ca, s1_cb, s1_cs, s1_y, s1_valid, s1_done}), 32'b00_000_0_1_0);
        s1_mode = 1'b0;

        // Sweep, WIDTH=1, STEP_DIV=4.
        s4_mode = 1'b1; s4_start = 1'b1;
        tick();
        s4_start = 1'b0;
        la = 1'b0; lb = 1'b0; ls = 3'd0; ly = 1'b0;
        for (int e = 1; e <= NS * 4 + 1; e++) begin
            tick();
            if (((e - 1) % 4 == 0) && (e <= NS * 4)) begin
                oi = ((e - 1) / 4) / GT; gi = ((e - 1) / 4) % GT;
                la = oi[1]; lb = oi[0]; ls = 3'(gi); ly = model1(la, lb, gi);
                $display("sweep4 edge=%0d a=%b b=%b sel=%0d y=%b", e, s4_ca, s4_cb, s4_cs, s4_y);
                check("s4_pulse", 32'(s4_valid), 32'd1);
            end else begin
                check("s4_gap", 32'(s4_valid), 32'd0);
            end
            check("s4_cur", 32'({s4_ca, s4_cb, s4_cs, s4_y}), 32'({la, lb, ls, ly}));
            check("s4_done", 32'(s4_done), (e == NS * 4 + 1) ? 32'd1 : 32'd0);
        end

        // Reset at step 10 of a fresh sweep.
        s4_mode = 1'b0;
        tick();
        s4_mode = 1'b1; s4_start = 1'b1;
        tick();
        s4_start = 1'b0;
        for (int e = 1; e <= 41; e++) tick();
        oi = 10 / GT; gi = 10 % GT;
        check("s4_step10", 32'({s4_valid, s4_ca, s4_cb, s4_cs}), 32'({1'b1, oi[1], oi[0], 3'(gi)}));
        #2;
        rst = 1'b1;
        #1;
        check("async_reset", 32'({s4_y, s4_ca, s4_cb, s4_cs, s4_valid, s4_done}), 32'd0);
        tick();
        rst = 1'b0;
        s4_start = 1'b1;
        tick();
        s4_start = 1'b0;
        tick();
        check("post_rst_first", 32'({s4_ca, s4_cb, s4_cs, s4_y, s4_valid}), 32'b00_000_0_1);

        // Abort from DWELL on the WIDTH=4 instance (reset left it in IDLE).
        u4_mode = 1'b1; u4_start = 1'b1;
        tick();
        u4_start = 1'b0;
        tick();
        check("u4_step0", 32'({u4_valid, u4_y}), 32'({1'b1, 4'b0000}));
        tick();
        check("u4_dwell", 32'(u4_valid), 32'd0);
        u4_mode = 1'b0; u4_a = 4'd3; u4_b = 4'd5; u4_sel = 3'd1;
        tick();
        check("abort_y", 32'(u4_y), 32'b0111);
        check("abort_vd", 32'({u4_valid, u4_done, u4_ca, u4_cb, u4_cs}), 32'({1'b1, 1'b0, 4'd3, 4'd5, 3'd1}));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
